// File: rtl/present_encrypt_iter.sv
// Iterative PRESENT-80 encryptor: one sLayer/pLayer round plus key-schedule step per clock, ciphertext valid ROUNDS edges after acceptance.
// Backpressure: the result is held in DONE until odat_ready; idat_ready stays low and no new block is taken meanwhile.
module present_encrypt_iter #(
   parameter int ROUNDS = 31,
   parameter int CNT_W  = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        idat_valid,
   output logic        idat_ready,
   input  logic [63:0] idat,
   input  logic [79:0] ikey,
   output logic        odat_valid,
   input  logic        odat_ready,
   output logic [63:0] odat,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS);
   localparam logic [CNT_W-1:0] FIRST_RND = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [63:0]      st;
   logic [79:0]      k;
   logic [CNT_W-1:0] rnd;

   logic [63:0]      round_out;
   logic [79:0]      key_rot;
   logic [79:0]      key_nxt;
   logic [4:0]       rnd_lo;
   logic             last_rnd;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int n = 0; n < 16; n++) begin
         y[4*n +: 4] = sbox(x[4*n +: 4]);
      end
      return y;
   endfunction

   // Bit i moves to 16*i mod 63; bit 63 is the fixed point of the permutation.
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 63; i++) begin
         y[(16*i) % 63] = x[i];
      end
      y[63] = x[63];
      return y;
   endfunction

   always_comb begin
      round_out       = p_layer(s_layer(st ^ k[79:16]));
      key_rot         = {k[18:0], k[79:19]};
      rnd_lo          = 5'(rnd);
      key_nxt         = key_rot;
      key_nxt[79:76]  = sbox(key_rot[79:76]);
      key_nxt[19:15]  = key_rot[19:15] ^ rnd_lo;
   end

   assign last_rnd = (rnd == LAST_RND);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (idat_valid) state_nxt = RUN;
         RUN:     if (last_rnd)   state_nxt = DONE;
         DONE:    if (odat_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ready is gated by rst_n so the host never sees a handshake opportunity during reset.
   always_comb begin
      idat_ready = rst_n && (state == IDLE);
      busy       = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= '0;
         k          <= '0;
         rnd        <= '0;
         odat       <= '0;
         odat_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (idat_valid) begin
                  st  <= idat;
                  k   <= ikey;
                  rnd <= FIRST_RND;
               end
            end
            RUN: begin
               st <= round_out;
               k  <= key_nxt;
               if (last_rnd) begin
                  // Final whitening uses the key produced on this same edge.
                  odat       <= round_out ^ key_nxt[79:16];
                  odat_valid <= 1'b1;
               end else begin
                  rnd <= rnd + FIRST_RND;
               end
            end
            DONE: begin
               if (odat_ready) odat_valid <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_present_encrypt_iter.sv
// Bench for present_encrypt_iter: known-answer vectors, randomized blocks against a textbook PRESENT model, handshake and reset scenarios.
`timescale 1ns/1ps
module tb_present_encrypt_iter;

   localparam int ROUNDS = 31;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        idat_valid, idat_ready, odat_valid, odat_ready, busy;
   logic [63:0] idat, odat;
   logic [79:0] ikey;

   logic        d1_idat_valid, d1_idat_ready, d1_odat_valid, d1_odat_ready, d1_busy;
   logic [63:0] d1_idat, d1_odat;
   logic [79:0] d1_ikey;

   int checks = 0;
   int failures = 0;

   logic [3:0] sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   present_encrypt_iter #(.ROUNDS(ROUNDS), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .idat_valid(idat_valid), .idat_ready(idat_ready), .idat(idat), .ikey(ikey),
      .odat_valid(odat_valid), .odat_ready(odat_ready), .odat(odat), .busy(busy)
   );

   present_encrypt_iter #(.ROUNDS(1), .CNT_W(1)) dut_r1 (
      .clk(clk), .rst_n(rst_n),
      .idat_valid(d1_idat_valid), .idat_ready(d1_idat_ready), .idat(d1_idat), .ikey(d1_ikey),
      .odat_valid(d1_odat_valid), .odat_ready(d1_odat_ready), .odat(d1_odat), .busy(d1_busy)
   );

   // Textbook PRESENT-80: addRoundKey, sLayer, pLayer per round, then the key update; final whitening.
   function automatic logic [63:0] present_ref(input logic [63:0] pt, input logic [79:0] key, input int rounds);
      logic [79:0] kr;
      logic [63:0] s;
      logic [63:0] t;
      kr = key;
      s  = pt;
      for (int r = 1; r <= rounds; r++) begin
         s = s ^ kr[79:16];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox_tab[s[4*n +: 4]];
         t = '0;
         for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16*i) % 63] = s[i];
         s = t;
         kr = {kr[18:0], kr[79:19]};
         kr[79:76] = sbox_tab[kr[79:76]];
         kr[19:15] = kr[19:15] ^ r[4:0];
      end
      return s ^ kr[79:16];
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [79:0] rand80();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[79:0];
   endfunction

   // Pushes one block through the main instance; lat counts edges from acceptance to odat_valid.
   task automatic do_block(input logic [63:0] pt, input logic [79:0] key, input bit early_rdy,
                           output logic [63:0] ct, output int lat, output bit tmo);
      int guard;
      tmo   = 1'b0;
      guard = 0;
      @(negedge clk);
      while (!idat_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!idat_ready) tmo = 1'b1;
      idat = pt; ikey = key; idat_valid = 1'b1; odat_ready = early_rdy;
      @(negedge clk);
      idat_valid = 1'b0; idat = rand64(); ikey = rand80();
      lat = 0;
      while (!odat_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!odat_valid) tmo = 1'b1;
      ct = odat;
      odat_ready = 1'b1;
      @(negedge clk);
      odat_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (idat_ready !== 1'b0 || odat_valid !== 1'b0 || busy !== 1'b0 || odat !== 64'h0) begin
         failures++;
         $display("FAIL reset_values got ready=%b vld=%b busy=%b odat=%h exp 0 0 0 0", idat_ready, odat_valid, busy, odat);
      end
      checks++;
      if (d1_idat_ready !== 1'b0 || d1_odat_valid !== 1'b0 || d1_odat !== 64'h0) begin
         failures++;
         $display("FAIL reset_values_r1 got ready=%b vld=%b odat=%h exp 0 0 0", d1_idat_ready, d1_odat_valid, d1_odat);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (idat_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got ready=%b busy=%b exp 1 0", idat_ready, busy);
      end
   endtask

   task automatic test_known_vectors();
      logic [63:0] pts [3] = '{64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      logic [79:0] keys [3] = '{80'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'h0};
      logic [63:0] cts [3] = '{64'h5579_C138_7B22_8445, 64'hE72C_46C0_F594_5049, 64'hA112_FFC7_2F68_417B};
      logic [63:0] ct;
      int lat;
      bit tmo;
      for (int v = 0; v < 3; v++) begin
         do_block(pts[v], keys[v], 1'b0, ct, lat, tmo);
         checks++;
         if (tmo || ct !== cts[v]) begin
            failures++;
            $display("FAIL kat_%0d got=%h exp=%h tmo=%b", v, ct, cts[v], tmo);
         end
         checks++;
         if (lat !== ROUNDS) begin
            failures++;
            $display("FAIL kat_latency_%0d got=%0d exp=%0d", v, lat, ROUNDS);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clk);
      idat = '1; ikey = '1; idat_valid = 1'b1; odat_ready = 1'b0;
      @(negedge clk);
      idat = rand64(); ikey = rand80();
      lat = 0;
      while (!odat_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== ROUNDS) begin
         failures++;
         $display("FAIL bp_latency got=%0d exp=%0d", lat, ROUNDS);
      end
      // idat_valid stays high throughout the stall; it must be ignored.
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (odat !== 64'h3333_DCD3_2132_10D2 || odat_valid !== 1'b1 || idat_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold_%0d got odat=%h vld=%b ready=%b busy=%b exp 3333dcd3213210d2 1 0 1",
                     c, odat, odat_valid, idat_ready, busy);
         end
         idat = rand64(); ikey = rand80();
         @(negedge clk);
      end
      idat_valid = 1'b0;
      odat_ready = 1'b1;
      #1;
      checks++;
      if (odat_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_before_edge got vld=%b exp 1", odat_valid);
      end
      @(negedge clk);
      odat_ready = 1'b0;
      checks++;
      if (odat_valid !== 1'b0 || idat_ready !== 1'b1 || busy !== 1'b0 || odat !== 64'h3333_DCD3_2132_10D2) begin
         failures++;
         $display("FAIL bp_release got vld=%b ready=%b busy=%b odat=%h exp 0 1 0 3333dcd3213210d2",
                  odat_valid, idat_ready, busy, odat);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] pts [4];
      logic [79:0] keys [4];
      int acc_cyc [4];
      int n_acc, n_out, cyc;
      for (int i = 0; i < 4; i++) begin
         pts[i] = rand64();
         keys[i] = rand80();
      end
      n_acc = 0; n_out = 0; cyc = 0;
      @(negedge clk);
      idat = pts[0]; ikey = keys[0]; idat_valid = 1'b1; odat_ready = 1'b1;
      while (n_out < 4 && cyc < 400) begin
         if (odat_valid) begin
            checks++;
            if (odat !== present_ref(pts[n_out], keys[n_out], ROUNDS)) begin
               failures++;
               $display("FAIL b2b_ct_%0d got=%h exp=%h", n_out, odat, present_ref(pts[n_out], keys[n_out], ROUNDS));
            end
            n_out++;
         end
         if (idat_ready && n_acc < 4) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
         end else if (odat_valid && n_acc < 4) begin
            idat = pts[n_acc]; ikey = keys[n_acc];
         end else begin
            idat = rand64(); ikey = rand80();
         end
         @(negedge clk);
         cyc++;
      end
      idat_valid = 1'b0;
      odat_ready = 1'b0;
      checks++;
      if (n_out !== 4 || n_acc !== 4) begin
         failures++;
         $display("FAIL b2b_count got outputs=%0d accepts=%0d exp 4 4", n_out, n_acc);
      end
      // Period: acceptance, ROUNDS RUN edges ending in DONE, the handshake edge, then one IDLE edge.
      for (int i = 1; i < n_acc; i++) begin
         checks++;
         if (acc_cyc[i] - acc_cyc[i-1] !== ROUNDS + 2) begin
            failures++;
            $display("FAIL b2b_spacing_%0d got=%0d exp=%0d", i, acc_cyc[i] - acc_cyc[i-1], ROUNDS + 2);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [63:0] ct;
      int lat;
      bit tmo;
      @(negedge clk);
      idat = rand64(); ikey = rand80(); idat_valid = 1'b1;
      @(negedge clk);
      idat_valid = 1'b0;
      repeat (14) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || odat === 64'h0) begin
         failures++;
         $display("FAIL midrun_pre got busy=%b odat=%h exp busy=1 odat nonzero", busy, odat);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (odat !== 64'h0 || odat_valid !== 1'b0 || busy !== 1'b0 || idat_ready !== 1'b0) begin
         failures++;
         $display("FAIL midrun_async got odat=%h vld=%b busy=%b ready=%b exp 0 0 0 0", odat, odat_valid, busy, idat_ready);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (odat_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_pulse got vld=%b exp 0", odat_valid);
         end
      end
      rst_n = 1'b1;
      do_block(64'h0, 80'h0, 1'b0, ct, lat, tmo);
      checks++;
      if (tmo || ct !== 64'h5579_C138_7B22_8445 || lat !== ROUNDS) begin
         failures++;
         $display("FAIL midrun_after got=%h lat=%0d tmo=%b exp=5579c1387b228445 lat=%0d", ct, lat, tmo, ROUNDS);
      end
   endtask

   task automatic test_random();
      logic [63:0] pt, ct, exp_ct;
      logic [79:0] key;
      int lat;
      bit tmo, early;
      for (int v = 0; v < 5; v++) begin
         pt = rand64(); key = rand80(); early = 1'($urandom_range(0, 1));
         exp_ct = present_ref(pt, key, ROUNDS);
         do_block(pt, key, early, ct, lat, tmo);
         checks++;
         if (tmo || ct !== exp_ct || lat !== ROUNDS) begin
            failures++;
            $display("FAIL random_%0d got=%h lat=%0d tmo=%b exp=%h lat=%0d early=%b", v, ct, lat, tmo, exp_ct, ROUNDS, early);
         end
      end
   endtask

   task automatic test_rounds1();
      logic [63:0] pt;
      logic [79:0] key;
      for (int v = 0; v < 3; v++) begin
         pt  = (v == 0) ? 64'h0 : rand64();
         key = (v == 0) ? 80'h0 : rand80();
         @(negedge clk);
         checks++;
         if (d1_idat_ready !== 1'b1) begin
            failures++;
            $display("FAIL r1_ready_%0d got=%b exp=1", v, d1_idat_ready);
         end
         d1_idat = pt; d1_ikey = key; d1_idat_valid = 1'b1;
         @(negedge clk);
         d1_idat_valid = 1'b0;
         checks++;
         if (d1_odat_valid !== 1'b0 || d1_busy !== 1'b1) begin
            failures++;
            $display("FAIL r1_run_%0d got vld=%b busy=%b exp 0 1", v, d1_odat_valid, d1_busy);
         end
         @(negedge clk);
         checks++;
         if (d1_odat_valid !== 1'b1 || d1_odat !== present_ref(pt, key, 1)) begin
            failures++;
            $display("FAIL r1_ct_%0d got vld=%b odat=%h exp vld=1 odat=%h", v, d1_odat_valid, d1_odat, present_ref(pt, key, 1));
         end
         d1_odat_ready = 1'b1;
         @(negedge clk);
         d1_odat_ready = 1'b0;
         checks++;
         if (d1_odat_valid !== 1'b0 || d1_busy !== 1'b0) begin
            failures++;
            $display("FAIL r1_release_%0d got vld=%b busy=%b exp 0 0", v, d1_odat_valid, d1_busy);
         end
      end
   endtask

   initial begin
      idat_valid = 1'b0; odat_ready = 1'b0; idat = '0; ikey = '0;
      d1_idat_valid = 1'b0; d1_odat_ready = 1'b0; d1_idat = '0; d1_ikey = '0;
      test_reset();
      test_known_vectors();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      test_rounds1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
